alu_display_sequencer: RTL
==========================

// Module: alu_display_sequencer
// PURPOSE
//  Sequences I2C display frames carrying the ALU result. Latches each new result and
//  encodes it as DIGITS hex 7-segment bytes. Issues START/ADDR/CTRL/DIGITs/STOP commands
//  to the byte-level I2C master over a valid/ready command channel.
//  Sits in alu_top between the ALU result mux and the I2C master that drives sda/seg_scl_o.
// PARAMETERS
//  WIDTH_MUX       16     result width; DIGITS = WIDTH_MUX/4 (must be a multiple of 4)
//  DEV_ADDR        7'h38  7-bit I2C address of the display driver
//  CTRL_BYTE       8'h00  control/register byte sent after the address
//  DISPLAY_CLK_DIV 1000   minimum idle gap, in clk_i cycles, between frames (>=1)
//  MAX_RETRY       3      NACKed frame attempts before giving up (>=1)
// PORTS
//  clk_i           in   1          system clock
//  reset_sw        in   1          synchronous reset, active-high
//  result_i        in   WIDTH_MUX  ALU result to display
//  result_valid_i  in   1          1-cycle strobe: result_i holds a new value
//  cmd_valid_o     out  1          command offered to the I2C master
//  cmd_ready_i     in   1          master accepts the command this cycle
//  cmd_o           out  2          00 START, 01 WRITE, 10 STOP, 11 reserved (never issued)
//  cmd_data_o      out  8          byte for WRITE; 8'h00 otherwise
//  rsp_valid_i     in   1          1-cycle strobe: WRITE finished, ack sampled
//  rsp_ack_i       in   1          1 = slave ACK, 0 = NACK; valid with rsp_valid_i
//  busy_o          out  1          1 in any state other than IDLE
//  frame_done_o    out  1          1-cycle pulse when STOP of an ACKed frame is accepted
//  nack_err_o      out  1          sticky; set when MAX_RETRY attempts all NACK
// BEHAVIOUR
//  Reset: every output 0, FSM=IDLE, dirty=0, retry=0, gap counter expired.
//  Result capture: result_valid_i loads pend_q<=result_i and sets dirty, in any state.
//    A capture and a snapshot in the same cycle: the new value stays pending, dirty=1.
//  FSM: IDLE -> LATCH -> START -> ADDR -> CTRL -> DIGIT -> STOP -> GAP -> IDLE.
//  FSM: error branch STOP -> IDLE on final failure (sets nack_err_o).
//   IDLE : go to LATCH when dirty && gap expired.
//   LATCH: snap_q<=pend_q, clear dirty, digit index=DIGITS-1.
//   START: offer cmd START.
//   ADDR : offer WRITE {DEV_ADDR,1'b0}.
//   CTRL : offer WRITE CTRL_BYTE.
//   DIGIT: offer WRITE seg(snap_q nibble[idx]), MS nibble first. Decrement idx per ACK.
//   STOP : offer STOP.
//  Handshake: cmd_valid_o is held, and cmd_o/cmd_data_o are stable, until the cycle with
//    cmd_valid_o && cmd_ready_i.
//  Handshake: after WRITE acceptance, cmd_valid_o=0 until rsp_valid_i. ACK advances the FSM.
//    NACK goes to STOP and marks the frame failed.
//  Failed frame:
//   - retry++. If retry<MAX_RETRY, dirty is re-set and pend_q is kept unless overwritten.
//     The next frame launches after the gap.
//   - Else nack_err_o<=1, retry<=0, frame dropped.
//   Success: retry<=0, frame_done_o pulses.
//  Gap: counter loads DISPLAY_CLK_DIV-1 on STOP acceptance. GAP state waits until it
//    reaches 0, then returns to IDLE.
//  Latency: result_valid_i in cycle N, FSM idle, gap expired -> LATCH in N+1.
//    cmd_valid_o=1 with START in N+2.
//  Snapshot isolates the frame: results arriving mid-frame never tear the current frame.
//    They produce exactly one further frame.
//  rsp_valid_i outside a wait-for-response state is ignored.
//  cmd_ready_i while cmd_valid_o=0 is ignored.
//  Reset mid-frame: immediate return to reset state. The STOP is not issued; the master's
//    own reset covers the bus.
//  Frame length: 1 START + (2+DIGITS) WRITE + 1 STOP = 8 commands at default parameters.
// STRUCTURE
//  Package alu_disp_pkg:
//   - localparams CMD_START=2'b00, CMD_WRITE=2'b01, CMD_STOP=2'b10
//   - FSM state encodings
//   - 16-entry hex-to-7seg table (gfedcba, active-high: 0->8'h3F, 1->8'h06, F->8'h71)
//  Sub-module hex_to_seg7: combinational 4-bit -> 8-bit segment encoder used for DIGIT bytes.
//  Everything else (FSM, retry, gap counter, capture regs) in this module.
// TESTING
//  1 Reset, result_i=16'h1234 strobe, ready=1, all ACK -> cmds START,W70,W00,W06,W5B,W4F,W66,
//    STOP; frame_done_o 1 pulse; idle gap >= 1000 cycles.
//  2 cmd_ready_i low 5 cycles on ADDR -> cmd_valid_o and cmd_data_o=8'h70 stay stable
//    until accepted.
//  3 NACK on ADDR every attempt -> 3 frames (START,W70,STOP) spaced by the gap.
//    Then nack_err_o=1 and the FSM is IDLE.
//  4 Strobe 16'hABCD during DIGIT of the 16'h1234 frame -> first frame unchanged.
//    Exactly one extra frame shows 77,7C,39,5E.
//  5 Two strobes in the gap (16'h0001 then 16'h00FF) -> one frame after the gap with 3F,3F,71,71.
//  6 reset_sw during CTRL wait -> next cycle all outputs 0, busy_o=0; no further commands.

Source files
------------

// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU result display sequencer: I2C master command
// codes, sequencer FSM states and the hex-to-7-segment lookup table.
package alu_disp_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_START,
        ST_ADDR,
        ST_CTRL,
        ST_DIGIT,
        ST_STOP,
        ST_GAP
    } state_e;

    // Segment order gfedcba, active-high.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to 7-segment byte encoder used for the DIGIT bytes.
module hex_to_seg7
    import alu_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] seg_o
);

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/alu_display_sequencer.sv
// Snapshots the latest ALU result and streams it to an I2C display driver as a
// START / address / control / digit bytes / STOP frame, with NACK retry and inter-frame gap.
module alu_display_sequencer
    import alu_disp_pkg::*;
#(
    parameter int          WIDTH_MUX       = 16,
    parameter logic [6:0]  DEV_ADDR        = 7'h38,
    parameter logic [7:0]  CTRL_BYTE       = 8'h00,
    parameter int          DISPLAY_CLK_DIV = 1000,
    parameter int          MAX_RETRY       = 3
) (
    input  logic                 clk_i,
    input  logic                 reset_sw,
    input  logic [WIDTH_MUX-1:0] result_i,
    input  logic                 result_valid_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [1:0]           cmd_o,
    output logic [7:0]           cmd_data_o,
    input  logic                 rsp_valid_i,
    input  logic                 rsp_ack_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 nack_err_o
);

    localparam int DIGITS = WIDTH_MUX / 4;
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GW     = (DISPLAY_CLK_DIV > 1) ? $clog2(DISPLAY_CLK_DIV) : 1;
    localparam int RW     = $clog2(MAX_RETRY + 1);

    state_e                 state_q, state_d;
    logic                   rsp_wait_q, rsp_wait_d;
    logic                   fail_q, fail_d;
    logic                   dirty_q, dirty_d;
    logic [WIDTH_MUX-1:0]   pend_q, pend_d;
    logic [WIDTH_MUX-1:0]   snap_q, snap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   frame_done_q, frame_done_d;
    logic                   nack_err_q, nack_err_d;

    logic [3:0]             nibble;
    logic [7:0]             digit_seg;
    logic [RW-1:0]          retry_inc;

    always_comb begin
        nibble = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) nibble = snap_q[i*4 +: 4];
        end
    end

    hex_to_seg7 u_seg (
        .hex_i (nibble),
        .seg_o (digit_seg)
    );

    assign retry_inc = retry_q + RW'(1);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d      = state_q;
        rsp_wait_d   = rsp_wait_q;
        fail_d       = fail_q;
        dirty_d      = dirty_q;
        pend_d       = pend_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        gap_d        = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        frame_done_d = 1'b0;
        nack_err_d   = nack_err_q;
        cmd_valid_o  = 1'b0;
        cmd_o        = CMD_START;
        cmd_data_o   = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                if ((dirty_q || result_valid_i) && gap_q == '0) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                snap_d     = pend_q;
                dirty_d    = 1'b0;
                idx_d      = IW'(DIGITS - 1);
                fail_d     = 1'b0;
                rsp_wait_d = 1'b0;
                state_d    = ST_START;
            end
            ST_START: begin
                cmd_valid_o = 1'b1;
                cmd_o       = CMD_START;
                if (cmd_ready_i) state_d = ST_ADDR;
            end
            ST_ADDR, ST_CTRL, ST_DIGIT: begin
                if (!rsp_wait_q) begin
                    cmd_valid_o = 1'b1;
                    cmd_o       = CMD_WRITE;
                    if (state_q == ST_ADDR)      cmd_data_o = {DEV_ADDR, 1'b0};
                    else if (state_q == ST_CTRL) cmd_data_o = CTRL_BYTE;
                    else                         cmd_data_o = digit_seg;
                    if (cmd_ready_i) rsp_wait_d = 1'b1;
                end else if (rsp_valid_i) begin
                    rsp_wait_d = 1'b0;
                    if (!rsp_ack_i) begin
                        fail_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (state_q == ST_ADDR) begin
                        state_d = ST_CTRL;
                    end else if (state_q == ST_CTRL) begin
                        state_d = ST_DIGIT;
                    end else if (idx_q == '0) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q - IW'(1);
                    end
                end
            end
            ST_STOP: begin
                cmd_valid_o = 1'b1;
                cmd_o       = CMD_STOP;
                if (cmd_ready_i) begin
                    gap_d = GW'(DISPLAY_CLK_DIV - 1);
                    if (!fail_q) begin
                        retry_d      = '0;
                        frame_done_d = 1'b1;
                        state_d      = ST_GAP;
                    end else if (retry_inc < RW'(MAX_RETRY)) begin
                        retry_d = retry_inc;
                        dirty_d = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        // Give up on this value; the gap still runs down while idle.
                        retry_d    = '0;
                        nack_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new result always wins over a snapshot clear in the same cycle.
        if (result_valid_i) begin
            pend_d  = result_i;
            dirty_d = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_sw) begin
            state_q      <= ST_IDLE;
            rsp_wait_q   <= 1'b0;
            fail_q       <= 1'b0;
            dirty_q      <= 1'b0;
            pend_q       <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            retry_q      <= '0;
            gap_q        <= '0;
            frame_done_q <= 1'b0;
            nack_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_wait_q   <= rsp_wait_d;
            fail_q       <= fail_d;
            dirty_q      <= dirty_d;
            pend_q       <= pend_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            gap_q        <= gap_d;
            frame_done_q <= frame_done_d;
            nack_err_q   <= nack_err_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign frame_done_o = frame_done_q;
    assign nack_err_o   = nack_err_q;

endmodule
